// File: rtl/jpeg_parser.sv
// JPEG marker/header parser that forwards the entropy-coded scan bytes.
// Define JPEG_PARSER_UNSTUFF_EN to collapse FF 00 stuffing into a single FF.
module jpeg_parser #(
  parameter logic [15:0] IMG_WIDTH  = 16'd128,
  parameter logic [15:0] IMG_HEIGHT = 16'd128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  jpeg_data,
  input  logic        jpeg_data_vaild,
  input  logic        jpeg_data_last,
  output logic [7:0]  Compress_data,
  output logic        Compress_data_vaild,
  output logic        Compress_data_last,
  output logic [15:0] img_width,
  output logic [15:0] img_height,
  output logic [3:0]  dqt_cnt,
  output logic [3:0]  dht_cnt,
  output logic        header_done,
  output logic        err,
  output logic [2:0]  err_code
);

  typedef enum logic [3:0] {
    IDLE, MARK_FF, MARK_ID, LEN_H, LEN_L, SKIP,
    SOF_BODY, SOS_BODY, DATA, DATA_FF, ERR
  } state_t;

  state_t      state, body_st;
  logic        in_hdr, sof_bad, pend_vld;
  logic [7:0]  len_hi, pend_data;
  logic [15:0] cnt;
  logic [2:0]  pos;

  logic        is_ff, is_rst, is_eoi, known;
  logic        fin, sof_bad_nx, trunc, fault;
  logic [15:0] len;
  logic [2:0]  ecode, code;

  assign is_ff  = jpeg_data == 8'hFF;
  assign is_rst = jpeg_data[7:3] == 5'b11010;
  assign is_eoi = jpeg_data == 8'hD9;
  assign known  = jpeg_data[7:4] == 4'hE
               || jpeg_data == 8'hDB
               || jpeg_data == 8'hC4
               || jpeg_data == 8'hC0
               || jpeg_data == 8'hDA;
  assign len    = {len_hi, jpeg_data};
  assign fin    = cnt == 16'd1;
  assign sof_bad_nx = sof_bad
    | (pos == 3'd0 && jpeg_data != 8'd8)
    | (pos == 3'd5 && jpeg_data != 8'd3);

  always_comb begin
    ecode = 3'd0;
    case (state)
      IDLE:
        if (!is_ff) ecode = 3'd1;
      MARK_FF:
        if (!is_ff) begin
          if (!in_hdr) begin
            if (jpeg_data != 8'hD8) ecode = 3'd1;
          end else if (!known) begin
            ecode = 3'd3;
          end
        end
      MARK_ID:
        if (!is_ff) ecode = 3'd3;
      LEN_L:
        if (len < 16'd2) ecode = 3'd2;
        else if (len == 16'd2 && body_st == SOF_BODY)
          ecode = 3'd4;
      SOF_BODY:
        if (fin && (sof_bad_nx || pos < 3'd5
            || img_height != IMG_HEIGHT
            || img_width != IMG_WIDTH))
          ecode = 3'd4;
      DATA_FF:
        if (!(jpeg_data == 8'h00 || is_rst || is_eoi))
          ecode = 3'd6;
      default: ;
    endcase
  end

  // Only the EOI byte itself may carry the end-of-stream flag.
  assign trunc = jpeg_data_last && state != ERR
              && !(state == DATA_FF && is_eoi);
  assign code  = (trunc && (ecode == 3'd0 || ecode == 3'd6))
               ? 3'd5 : ecode;
  assign fault = jpeg_data_vaild && code != 3'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      body_st             <= SKIP;
      in_hdr              <= 1'b0;
      sof_bad             <= 1'b0;
      pend_vld            <= 1'b0;
      pend_data           <= 8'd0;
      len_hi              <= 8'd0;
      cnt                 <= 16'd0;
      pos                 <= 3'd0;
      Compress_data       <= 8'd0;
      Compress_data_vaild <= 1'b0;
      Compress_data_last  <= 1'b0;
      img_width           <= 16'd0;
      img_height          <= 16'd0;
      dqt_cnt             <= 4'd0;
      dht_cnt             <= 4'd0;
      header_done         <= 1'b0;
      err                 <= 1'b0;
      err_code            <= 3'd0;
    end else begin
      Compress_data_vaild <= 1'b0;
      Compress_data_last  <= 1'b0;
      header_done         <= 1'b0;
      if (pend_vld) begin
        Compress_data       <= pend_data;
        Compress_data_vaild <= 1'b1;
        pend_vld            <= 1'b0;
      end
      if (fault) begin
        err                 <= 1'b1;
        err_code            <= code;
        in_hdr              <= 1'b0;
        pend_vld            <= 1'b0;
        Compress_data_vaild <= 1'b0;
        state <= jpeg_data_last ? IDLE : ERR;
      end else if (jpeg_data_vaild) begin
        case (state)
          IDLE: begin
            in_hdr <= 1'b0;
            state  <= MARK_FF;
          end
          MARK_FF:
            if (!is_ff) begin
              if (!in_hdr) begin
                in_hdr   <= 1'b1;
                dqt_cnt  <= 4'd0;
                dht_cnt  <= 4'd0;
                err      <= 1'b0;
                err_code <= 3'd0;
                state    <= MARK_ID;
              end else begin
                unique case (1'b1)
                  jpeg_data == 8'hC0: body_st <= SOF_BODY;
                  jpeg_data == 8'hDA: body_st <= SOS_BODY;
                  default:            body_st <= SKIP;
                endcase
                if (jpeg_data == 8'hDB && dqt_cnt != 4'd15)
                  dqt_cnt <= dqt_cnt + 4'd1;
                if (jpeg_data == 8'hC4 && dht_cnt != 4'd15)
                  dht_cnt <= dht_cnt + 4'd1;
                state <= LEN_H;
              end
            end
          MARK_ID: state <= MARK_FF;
          LEN_H: begin
            len_hi <= jpeg_data;
            state  <= LEN_L;
          end
          LEN_L: begin
            cnt     <= len - 16'd2;
            pos     <= 3'd0;
            sof_bad <= 1'b0;
            if (len == 16'd2) begin
              if (body_st == SOS_BODY) begin
                header_done <= 1'b1;
                state       <= DATA;
              end else begin
                state <= MARK_ID;
              end
            end else begin
              state <= body_st;
            end
          end
          SKIP: begin
            cnt <= cnt - 16'd1;
            if (fin) state <= MARK_ID;
          end
          SOF_BODY: begin
            cnt     <= cnt - 16'd1;
            sof_bad <= sof_bad_nx;
            if (pos != 3'd7) pos <= pos + 3'd1;
            case (pos)
              3'd1: img_height[15:8] <= jpeg_data;
              3'd2: img_height[7:0]  <= jpeg_data;
              3'd3: img_width[15:8]  <= jpeg_data;
              3'd4: img_width[7:0]   <= jpeg_data;
              default: ;
            endcase
            if (fin) state <= MARK_ID;
          end
          SOS_BODY: begin
            cnt <= cnt - 16'd1;
            if (fin) begin
              header_done <= 1'b1;
              state       <= DATA;
            end
          end
          DATA:
            if (is_ff) begin
              state <= DATA_FF;
            end else if (pend_vld) begin
              pend_data <= jpeg_data;
              pend_vld  <= 1'b1;
            end else begin
              Compress_data       <= jpeg_data;
              Compress_data_vaild <= 1'b1;
            end
          DATA_FF:
            if (is_eoi) begin
              Compress_data_last <= 1'b1;
              in_hdr             <= 1'b0;
              state              <= IDLE;
            end else if (is_rst) begin
              state <= DATA;
            end else begin
              Compress_data       <= 8'hFF;
              Compress_data_vaild <= 1'b1;
`ifndef JPEG_PARSER_UNSTUFF_EN
              // Stuffed zero follows the FF one cycle later.
              pend_data <= 8'h00;
              pend_vld  <= 1'b1;
`endif
              state <= DATA;
            end
          ERR:
            if (jpeg_data_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jpeg_parser.sv
// Directed self-checking bench for jpeg_parser (default 128x128 params).
module tb_jpeg_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  jpeg_data;
  logic        vld;
  logic        lst;
  logic [7:0]  cd;
  logic        cd_vld;
  logic        cd_last;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic [3:0]  dqt_cnt;
  logic [3:0]  dht_cnt;
  logic        hdone;
  logic        err;
  logic [2:0]  err_code;

  int total = 0;
  int bad = 0;
  int lastn = 0;
  int hdn = 0;
  logic [7:0] s[$];
  logic [7:0] outq[$];

  always #5 clk = ~clk;

  jpeg_parser dut (
    .clk(clk),
    .rst_n(rst_n),
    .jpeg_data(jpeg_data),
    .jpeg_data_vaild(vld),
    .jpeg_data_last(lst),
    .Compress_data(cd),
    .Compress_data_vaild(cd_vld),
    .Compress_data_last(cd_last),
    .img_width(img_width),
    .img_height(img_height),
    .dqt_cnt(dqt_cnt),
    .dht_cnt(dht_cnt),
    .header_done(hdone),
    .err(err),
    .err_code(err_code)
  );

  always @(negedge clk) begin
    if (cd_vld) outq.push_back(cd);
    if (cd_last) lastn = lastn + 1;
    if (hdone) hdn = hdn + 1;
  end

  task automatic put(input logic [7:0] b, input logic l);
    jpeg_data = b;
    vld = 1'b1;
    lst = l;
    @(negedge clk);
    vld = 1'b0;
    lst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    outq.delete();
    lastn = 0;
    hdn = 0;
  endtask

  task automatic add_seg(input logic [7:0] m, input int body);
    int len;
    len = body + 2;
    s.push_back(8'hFF);
    s.push_back(m);
    s.push_back(len[15:8]);
    s.push_back(len[7:0]);
    for (int i = 0; i < body; i++) s.push_back(8'(i));
  endtask

  task automatic add_sof(input logic [15:0] h, input logic [15:0] w);
    logic [7:0] tl [10];
    tl = '{8'h03, 8'h01, 8'h22, 8'h00, 8'h02,
           8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
    s.push_back(8'hFF); s.push_back(8'hC0);
    s.push_back(8'h00); s.push_back(8'h11);
    s.push_back(8'h08);
    s.push_back(h[15:8]); s.push_back(h[7:0]);
    s.push_back(w[15:8]); s.push_back(w[7:0]);
    for (int i = 0; i < 10; i++) s.push_back(tl[i]);
  endtask

  task automatic add_hdr(input logic [15:0] w);
    s.push_back(8'hFF); s.push_back(8'hD8);
    add_seg(8'hE0, 14);
    add_seg(8'hDB, 65);
    add_seg(8'hDB, 65);
    add_sof(16'd128, w);
    for (int i = 0; i < 4; i++) add_seg(8'hC4, 18);
    add_seg(8'hDA, 10);
  endtask

  task automatic play(input logic l);
    for (int i = 0; i < s.size(); i++)
      put(s[i], l && (i == s.size() - 1));
    s.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = 1'b0;
    lst = 1'b0;
    jpeg_data = 8'h00;
    idle(3);
    total++;
    if ({cd_vld, cd_last, hdone} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=000",
               {cd_vld, cd_last, hdone});
    end
    total++;
    if (cd !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h want=00", cd);
    end
    total++;
    if ({img_width, img_height} !== 32'h0) begin
      bad++;
      $display("FAIL reset_size got=%h want=0",
               {img_width, img_height});
    end
    total++;
    if ({dqt_cnt, dht_cnt} !== 8'h00) begin
      bad++;
      $display("FAIL reset_cnt got=%h want=00", {dqt_cnt, dht_cnt});
    end
    total++;
    if ({err, err_code} !== 4'h0) begin
      bad++;
      $display("FAIL reset_err got=%h want=0", {err, err_code});
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_header();
    clear_mon();
    add_hdr(16'd128);
    s.push_back(8'hFF); s.push_back(8'hD9);
    play(1'b1);
    idle(3);
    total++;
    if (hdn != 1) begin
      bad++; $display("FAIL hdr_done got=%0d want=1", hdn);
    end
    total++;
    if (dqt_cnt !== 4'd2) begin
      bad++; $display("FAIL hdr_dqt got=%0d want=2", dqt_cnt);
    end
    total++;
    if (dht_cnt !== 4'd4) begin
      bad++; $display("FAIL hdr_dht got=%0d want=4", dht_cnt);
    end
    total++;
    if (img_width !== 16'd128) begin
      bad++; $display("FAIL hdr_width got=%0d want=128", img_width);
    end
    total++;
    if (img_height !== 16'd128) begin
      bad++; $display("FAIL hdr_height got=%0d want=128", img_height);
    end
    total++;
    if (lastn != 1) begin
      bad++; $display("FAIL hdr_last got=%0d want=1", lastn);
    end
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL hdr_err got=%b want=0", err);
    end
    total++;
    if (outq.size() != 0) begin
      bad++; $display("FAIL hdr_nodata got=%0d want=0", outq.size());
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp[$];
`ifdef JPEG_PARSER_UNSTUFF_EN
    exp = '{8'h12, 8'h34, 8'hFF, 8'h56};
`else
    exp = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56};
`endif
    clear_mon();
    add_hdr(16'd128);
    s.push_back(8'h12); s.push_back(8'h34);
    s.push_back(8'hFF); s.push_back(8'h00);
    s.push_back(8'h56);
    s.push_back(8'hFF); s.push_back(8'hD9);
    play(1'b1);
    idle(3);
    total++;
    if (outq.size() != exp.size()) begin
      bad++;
      $display("FAIL scan_count got=%0d want=%0d",
               outq.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (outq[i] !== exp[i]) begin
          bad++;
          $display("FAIL scan_byte%0d got=%h want=%h",
                   i, outq[i], exp[i]);
        end
      end
    end
    total++;
    if (lastn != 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL scan_end got=last%0d/err%b want=last1/err0",
               lastn, err);
    end
  endtask

  task automatic test_latency();
    clear_mon();
    add_hdr(16'd128);
    play(1'b0);
    total++;
    if (hdone !== 1'b1) begin
      bad++; $display("FAIL lat_hdone got=%b want=1", hdone);
    end
    put(8'hAB, 1'b0);
    total++;
    if ({cd_vld, cd} !== {1'b1, 8'hAB}) begin
      bad++;
      $display("FAIL lat_byte got=%b/%h want=1/ab", cd_vld, cd);
    end
    put(8'hFF, 1'b0);
    total++;
    if (cd_vld !== 1'b0) begin
      bad++; $display("FAIL lat_ff got=%b want=0", cd_vld);
    end
    put(8'hD3, 1'b0);
    put(8'hCD, 1'b0);
    total++;
    if ({cd_vld, cd} !== {1'b1, 8'hCD}) begin
      bad++;
      $display("FAIL lat_rst got=%b/%h want=1/cd", cd_vld, cd);
    end
    put(8'hFF, 1'b0);
    put(8'hD9, 1'b1);
    total++;
    if ({cd_last, cd_vld} !== 2'b10) begin
      bad++;
      $display("FAIL lat_eoi got=%b want=10", {cd_last, cd_vld});
    end
    idle(2);
    total++;
    if (outq.size() != 2) begin
      bad++; $display("FAIL lat_count got=%0d want=2", outq.size());
    end
  endtask

  task automatic test_missing_soi();
    clear_mon();
    put(8'hFF, 1'b0);
    put(8'hE0, 1'b0);
    total++;
    if ({err, err_code} !== {1'b1, 3'd1}) begin
      bad++;
      $display("FAIL nosoi_err got=%b/%0d want=1/1", err, err_code);
    end
    put(8'h00, 1'b1);
    idle(2);
    total++;
    if (hdn != 0 || err_code !== 3'd1) begin
      bad++;
      $display("FAIL nosoi_keep got=hd%0d/code%0d want=hd0/code1",
               hdn, err_code);
    end
  endtask

  task automatic test_sof_mismatch();
    logic [7:0] fb;
    s.push_back(8'hFF); s.push_back(8'hD8);
    add_sof(16'd128, 16'h0100);
    fb = s.pop_back();
    play(1'b0);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL sof_early got=%b want=0", err);
    end
    put(fb, 1'b0);
    total++;
    if ({err, err_code} !== {1'b1, 3'd4}) begin
      bad++;
      $display("FAIL sof_err got=%b/%0d want=1/4", err, err_code);
    end
    total++;
    if (img_width !== 16'h0100) begin
      bad++; $display("FAIL sof_width got=%h want=0100", img_width);
    end
    put(8'h00, 1'b1);
    idle(2);
  endtask

  task automatic test_trunc();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hC4, 8'h00, 8'h14, 8'h01, 8'h02};
    play(1'b0);
    put(8'h03, 1'b1);
    total++;
    if ({err, err_code} !== {1'b1, 3'd5}) begin
      bad++;
      $display("FAIL trunc_err got=%b/%0d want=1/5", err, err_code);
    end
    total++;
    if (dht_cnt !== 4'd1) begin
      bad++; $display("FAIL trunc_dht got=%0d want=1", dht_cnt);
    end
    put(8'hFF, 1'b0);
    put(8'hD8, 1'b0);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL trunc_idle got=%b want=0", err);
    end
    s = '{8'hFF, 8'hDA, 8'h00, 8'h02, 8'hFF, 8'hD9};
    play(1'b1);
    idle(2);
  endtask

  task automatic test_bad_len();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00};
    play(1'b0);
    put(8'h01, 1'b1);
    total++;
    if ({err, err_code} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL badlen_err got=%b/%0d want=1/2", err, err_code);
    end
    idle(1);
  endtask

  task automatic test_stuff_err();
    clear_mon();
    s = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h12, 8'hFF};
    play(1'b0);
    put(8'h34, 1'b0);
    total++;
    if ({err, err_code} !== {1'b1, 3'd6}) begin
      bad++;
      $display("FAIL stuff_err got=%b/%0d want=1/6", err, err_code);
    end
    put(8'h00, 1'b1);
    idle(2);
    total++;
    if (outq.size() != 1 || lastn != 0) begin
      bad++;
      $display("FAIL stuff_out got=n%0d/last%0d want=n1/last0",
               outq.size(), lastn);
    end
  endtask

  task automatic test_saturate();
    clear_mon();
    s.push_back(8'hFF); s.push_back(8'hD8);
    for (int i = 0; i < 17; i++) add_seg(8'hDB, 0);
    add_seg(8'hDA, 0);
    s.push_back(8'hFF); s.push_back(8'hD9);
    play(1'b1);
    idle(2);
    total++;
    if (dqt_cnt !== 4'd15) begin
      bad++; $display("FAIL sat_dqt got=%0d want=15", dqt_cnt);
    end
    total++;
    if (err !== 1'b0 || lastn != 1 || hdn != 1) begin
      bad++;
      $display("FAIL sat_end got=e%b/l%0d/h%0d want=e0/l1/h1",
               err, lastn, hdn);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    add_hdr(16'd128);
    s.push_back(8'h11); s.push_back(8'h22);
    play(1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    total++;
    if (lastn != 0) begin
      bad++; $display("FAIL rmid_nolast got=%0d want=0", lastn);
    end
    total++;
    if ({err, dqt_cnt, img_width} !== 21'h0) begin
      bad++;
      $display("FAIL rmid_clear got=%h want=0",
               {err, dqt_cnt, img_width});
    end
    clear_mon();
    add_hdr(16'd128);
    s.push_back(8'h55);
    s.push_back(8'hFF); s.push_back(8'hD9);
    play(1'b1);
    idle(3);
    total++;
    if (outq.size() != 1 || outq[0] !== 8'h55) begin
      bad++;
      $display("FAIL rmid_data got=n%0d want=n1/55", outq.size());
    end
    total++;
    if (lastn != 1 || hdn != 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL rmid_end got=l%0d/h%0d/e%b want=l1/h1/e0",
               lastn, hdn, err);
    end
  endtask

  initial begin
    test_reset();
    test_header();
    test_scan();
    test_latency();
    test_missing_soi();
    test_sof_mismatch();
    test_trunc();
    test_bad_len();
    test_stuff_err();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
